scope_frame_support: RTL and testbench
======================================

Name: scope_frame_support

Overview:
- Support block for the VGA oscilloscope display controller. It bundles three independent engines on one clock.
- Screen-clear sweep generator: emits every pixel coordinate of the 8-bit frame buffer with the background colour.
- Programmable delay timer: holds off between frames.
- 256-entry sample RAM: stores ADC samples and is read back by the trace drawer.
- Each engine has its own enable / local-reset / finished handshake, driven by the external display state machine.

Parameters:
- H_RES, 160, pixels per line swept by the clear engine (1..256).
- V_RES, 120, lines swept by the clear engine (1..256).
- BG_COLOR, 12'h000, RGB444 colour driven during the clear.
- DELAY_CYCLES, 10008, enabled clock cycles before the delay engine finishes (must be >= 1).
- GRID_COLOR, 12'h444, grid colour; used only with the optional feature.

Ports:
- clk  in  1  system/pixel clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high global reset.
- clear_enable  in  1  advance the clear sweep.
- clear_reset  in  1  synchronous local restart of the clear engine.
- clear_finished  out  1  sweep complete (sticky).
- clear_x  out  8  current pixel column.
- clear_y  out  8  current pixel row.
- clear_color  out  12  colour for (clear_x, clear_y).
- delay_enable  in  1  count enabled cycles.
- delay_reset  in  1  synchronous local restart of the delay engine.
- delay_finished  out  1  delay elapsed (sticky).
- ram_wdata  in  14  ADC sample to store.
- ram_waddr  in  8  write address.
- ram_wren  in  1  write strobe.
- ram_raddr  in  8  read address.
- ram_rden  in  1  read strobe.
- ram_q  out  8  registered read data.

Behaviour:
- Global reset (async, active-high): clear_x=0, clear_y=0, clear_finished=0, delay count=0, delay_finished=0, ram_q=0. RAM array contents are not reset. clear_color is combinational from (x,y) and equals BG_COLOR.
- Local resets are synchronous. They take priority over their engine's enable. They return that engine to its global-reset state.
- Clear engine, each enabled edge while not finished:
  - if x < H_RES-1: x <= x+1;
  - else x <= 0 and y <= y+1;
  - at pixel (H_RES-1, V_RES-1): x and y hold and clear_finished <= 1.
  - Result: finished rises on the edge that ends the cycle presenting the last pixel, so exactly H_RES*V_RES distinct pixels are presented and finished is high after H_RES*V_RES enabled edges.
- Clear engine, other conditions:
  - clear_enable low: counters hold.
  - After finished: counters hold at the last pixel and finished stays 1 until clear_reset or reset.
- Delay engine:
  - 14-bit counter (sized for DELAY_CYCLES up to 16383) increments on each edge with delay_enable=1 and finished=0.
  - When it reaches DELAY_CYCLES, delay_finished <= 1 on that same edge. Finished is therefore high after exactly DELAY_CYCLES enabled edges.
  - Finished is sticky. Enable low pauses the count without clearing it.
- Sample RAM: 256 x 8, single clock.
  - Write: ram_wren=1 writes mem[ram_waddr] <= ram_wdata[13:6] (upper 8 bits).
  - Read: ram_rden=1 sets ram_q <= mem[ram_raddr] with latency 1. With ram_rden=0, ram_q holds.
  - Read and write to the same address on the same edge: read returns the old data.
- The three engines never interact. Simultaneous activity on all of them is legal.

Optional Feature:
- Macro: CLEAR_GRID_EN.
- Defined: clear_color = GRID_COLOR when x[3:0]==0 or y[3:0]==0; otherwise BG_COLOR. Timing is unchanged.
- Undefined: clear_color is always BG_COLOR and GRID_COLOR is unused.

Decomposition:
- Shared package scope_pkg holds:
  - widths COORD_W=8, COLOR_W=12, SAMPLE_W=14, RAM_DW=8, RAM_AW=8;
  - colour constants;
  - default resolution constants.
- One sub-module, scope_sample_ram, holds the 256x8 array, write port and registered read port. Clear and delay remain inline.

Test Plan:
- H_RES=4, V_RES=3. Hold clear_enable high after reset → (x,y) walks (0,0),(1,0)..(3,0),(0,1)..(3,2). clear_finished rises after the 12th edge. Coordinates hold at (3,2). Colour is 12'h000 throughout.
- Deassert clear_enable mid-sweep at (2,1) for 5 cycles → coordinates frozen. Then pulse clear_reset together with clear_enable → next state is (0,0) with finished=0.
- DELAY_CYCLES=10. Enable for 4 cycles, pause 3, enable again → delay_finished rises after the 10th enabled edge and stays 1. delay_reset clears it.
- Write 14'h3FC0 to address 5 and 14'h0040 to address 6, then read address 5 then 6 → ram_q=8'hFF then 8'h01, each one cycle after its rden.
- Same-edge read and write to address 7 (old 8'h11, new wdata 14'h0AC0) → ram_q=8'h11. A following read returns 8'h2B.
- Assert reset asynchronously mid-sweep and mid-delay → outputs go to their reset values immediately. RAM array keeps its data, so a read of address 5 still returns 8'hFF.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared widths, colours and default geometry for the oscilloscope frame support block.
package scope_pkg;
  localparam int COORD_W  = 8;
  localparam int COLOR_W  = 12;
  localparam int SAMPLE_W = 14;
  localparam int RAM_DW   = 8;
  localparam int RAM_AW   = 8;
  localparam int DLY_W    = 14;

  localparam logic [COLOR_W-1:0] BG_COLOR_DEF   = 12'h000;
  localparam logic [COLOR_W-1:0] GRID_COLOR_DEF = 12'h444;

  localparam int H_RES_DEF        = 160;
  localparam int V_RES_DEF        = 120;
  localparam int DELAY_CYCLES_DEF = 10008;
endpackage

// File: rtl/scope_sample_ram.sv
// 256x8 ADC sample store: synchronous write, registered read returning old data on collision.
module scope_sample_ram
  import scope_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wren,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [RAM_DW-1:0] wdata,
  input  logic              rden,
  input  logic [RAM_AW-1:0] raddr,
  output logic [RAM_DW-1:0] q
);
  logic [RAM_DW-1:0] mem [2**RAM_AW];
  logic [RAM_DW-1:0] q_q;

  // Array is deliberately left out of reset so samples survive a global reset.
  always_ff @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q_q <= '0;
    else if (rden) q_q <= mem[raddr];
  end

  assign q = q_q;
endmodule

// File: rtl/scope_frame_support.sv
// Screen-clear sweep, inter-frame delay timer and sample RAM for the VGA scope.
// Optional grid overlay on the clear colour when CLEAR_GRID_EN is defined.
module scope_frame_support
  import scope_pkg::*;
#(
  parameter int                 H_RES        = H_RES_DEF,
  parameter int                 V_RES        = V_RES_DEF,
  parameter logic [COLOR_W-1:0] BG_COLOR     = BG_COLOR_DEF,
  parameter int                 DELAY_CYCLES = DELAY_CYCLES_DEF
`ifdef CLEAR_GRID_EN
  ,parameter logic [COLOR_W-1:0] GRID_COLOR  = GRID_COLOR_DEF
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_enable,
  input  logic                clear_reset,
  output logic                clear_finished,
  output logic [COORD_W-1:0]  clear_x,
  output logic [COORD_W-1:0]  clear_y,
  output logic [COLOR_W-1:0]  clear_color,
  input  logic                delay_enable,
  input  logic                delay_reset,
  output logic                delay_finished,
  input  logic [SAMPLE_W-1:0] ram_wdata,
  input  logic [RAM_AW-1:0]   ram_waddr,
  input  logic                ram_wren,
  input  logic [RAM_AW-1:0]   ram_raddr,
  input  logic                ram_rden,
  output logic [RAM_DW-1:0]   ram_q
);
  localparam logic [COORD_W-1:0] LAST_X   = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] LAST_Y   = COORD_W'(V_RES - 1);
  localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               cfin_q, cfin_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic               dfin_q, dfin_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cfin_d = cfin_q;
    if (clear_reset) begin
      x_d    = '0;
      y_d    = '0;
      cfin_d = 1'b0;
    end else if (clear_enable && !cfin_q) begin
      if (x_q != LAST_X) begin
        x_d = x_q + 1'b1;
      end else if (y_q != LAST_Y) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        cfin_d = 1'b1;  // last pixel has been presented; park here
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    dfin_d = dfin_q;
    if (delay_reset) begin
      cnt_d  = '0;
      dfin_d = 1'b0;
    end else if (delay_enable && !dfin_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == DLY_LAST) dfin_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      cfin_q <= 1'b0;
      cnt_q  <= '0;
      dfin_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cfin_q <= cfin_d;
      cnt_q  <= cnt_d;
      dfin_q <= dfin_d;
    end
  end

  assign clear_x        = x_q;
  assign clear_y        = y_q;
  assign clear_finished = cfin_q;
  assign delay_finished = dfin_q;

`ifdef CLEAR_GRID_EN
  assign clear_color = (x_q[3:0] == 4'd0 || y_q[3:0] == 4'd0) ? GRID_COLOR : BG_COLOR;
`else
  assign clear_color = BG_COLOR;
`endif

  // Only the top 8 bits of each ADC sample are displayed.
  logic unused_wlsb;
  assign unused_wlsb = &{1'b0, ram_wdata[SAMPLE_W-RAM_DW-1:0]};

  scope_sample_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .wren  (ram_wren),
    .waddr (ram_waddr),
    .wdata (ram_wdata[SAMPLE_W-1 -: RAM_DW]),
    .rden  (ram_rden),
    .raddr (ram_raddr),
    .q     (ram_q)
  );
endmodule

// File: tb/tb_scope_frame_support.sv
// Self-checking bench for scope_frame_support against a pixel-index / counter / array model.
module tb_scope_frame_support;
  localparam int H_T = 4;
  localparam int V_T = 3;
  localparam int D_T = 10;
  localparam logic [11:0] BG_T = 12'h000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_enable = 0, clear_reset = 0, delay_enable = 0, delay_reset = 0;
  logic ram_wren = 0, ram_rden = 0;
  logic [13:0] ram_wdata = '0;
  logic [7:0] ram_waddr = '0, ram_raddr = '0;
  logic clear_finished, delay_finished;
  logic [7:0] clear_x, clear_y, ram_q;
  logic [11:0] clear_color;

  int passed = 0;
  int total  = 0;

  // reference model: linear pixel index, enabled-edge count, plain memory array
  int p_m = 0;
  bit cf_m = 0;
  int dc_m = 0;
  bit df_m = 0;
  logic [7:0] mem_m [256];
  logic [7:0] q_m = '0;

  always #5 clk = ~clk;

  scope_frame_support #(.H_RES(H_T), .V_RES(V_T), .BG_COLOR(BG_T), .DELAY_CYCLES(D_T)) dut (
    .clk(clk), .reset(reset),
    .clear_enable(clear_enable), .clear_reset(clear_reset), .clear_finished(clear_finished),
    .clear_x(clear_x), .clear_y(clear_y), .clear_color(clear_color),
    .delay_enable(delay_enable), .delay_reset(delay_reset), .delay_finished(delay_finished),
    .ram_wdata(ram_wdata), .ram_waddr(ram_waddr), .ram_wren(ram_wren),
    .ram_raddr(ram_raddr), .ram_rden(ram_rden), .ram_q(ram_q)
  );

  task automatic model_reset();
    p_m = 0; cf_m = 0; dc_m = 0; df_m = 0; q_m = '0;
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic tick();
    bit ce = clear_enable, cr = clear_reset, de = delay_enable, dr = delay_reset;
    bit we = ram_wren, re = ram_rden;
    logic [7:0] wa = ram_waddr, ra = ram_raddr;
    logic [13:0] wd = ram_wdata;
    @(posedge clk); #1;
    if (cr) begin p_m = 0; cf_m = 0; end
    else if (ce && !cf_m) begin
      if (p_m == H_T*V_T - 1) cf_m = 1; else p_m++;
    end
    if (dr) begin dc_m = 0; df_m = 0; end
    else if (de && !df_m) begin
      dc_m++;
      if (dc_m == D_T) df_m = 1;
    end
    if (re) q_m = mem_m[ra];
    if (we) mem_m[wa] = wd[13:6];
  endtask

  task automatic test_reset();
    reset = 1'b1; #3; model_reset();
    total++;
    if ({clear_x, clear_y, clear_finished, clear_color, delay_finished, ram_q} !== 38'd0)
      $display("FAIL reset_state got x=%0d y=%0d cf=%b col=%h df=%b q=%h want all zero",
               clear_x, clear_y, clear_finished, clear_color, delay_finished, ram_q);
    else passed++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_clear_sweep();
    clear_enable = 1;
    for (int i = 0; i < H_T*V_T + 3; i++) begin
      total++;
      if (clear_x !== 8'(p_m % H_T) || clear_y !== 8'(p_m / H_T) || clear_finished !== cf_m ||
          clear_color !== BG_T)
        $display("FAIL sweep[%0d] got (%0d,%0d) cf=%b col=%h want (%0d,%0d) cf=%b col=%h", i,
                 clear_x, clear_y, clear_finished, clear_color, p_m % H_T, p_m / H_T, cf_m, BG_T);
      else passed++;
      tick();
    end
    // finished must be up after exactly H*V edges and parked at the last pixel
    total++;
    if (clear_finished !== 1'b1 || clear_x !== 8'(H_T-1) || clear_y !== 8'(V_T-1))
      $display("FAIL sweep_end got (%0d,%0d) cf=%b want (3,2) cf=1", clear_x, clear_y, clear_finished);
    else passed++;
    clear_enable = 0;
  endtask

  task automatic test_clear_pause_reset();
    clear_reset = 1; tick(); clear_reset = 0;
    clear_enable = 1;
    repeat (6) tick();
    clear_enable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (clear_x !== 8'd2 || clear_y !== 8'd1 || clear_finished !== 1'b0)
        $display("FAIL pause[%0d] got (%0d,%0d) cf=%b want (2,1) cf=0", i, clear_x, clear_y, clear_finished);
      else passed++;
    end
    clear_reset = 1; clear_enable = 1; tick();
    clear_reset = 0; clear_enable = 0;
    total++;
    if (clear_x !== 8'd0 || clear_y !== 8'd0 || clear_finished !== 1'b0)
      $display("FAIL local_clear_reset got (%0d,%0d) cf=%b want (0,0) cf=0", clear_x, clear_y, clear_finished);
    else passed++;
  endtask

  task automatic test_delay();
    int en_edges = 0;
    delay_reset = 1; tick(); delay_reset = 0;
    for (int i = 0; i < 16; i++) begin
      delay_enable = !(i >= 4 && i < 7);
      tick();
      if (delay_enable) en_edges++;
      total++;
      if (delay_finished !== (en_edges >= D_T) || delay_finished !== df_m)
        $display("FAIL delay[%0d] got df=%b want %b after %0d enabled edges", i, delay_finished,
                 en_edges >= D_T, en_edges);
      else passed++;
    end
    delay_enable = 0;
    delay_reset = 1; tick(); delay_reset = 0;
    total++;
    if (delay_finished !== 1'b0)
      $display("FAIL delay_reset got df=%b want 0", delay_finished);
    else passed++;
  endtask

  task automatic test_ram();
    ram_wren = 1; ram_waddr = 8'd5; ram_wdata = 14'h3FC0; tick();
    ram_waddr = 8'd6; ram_wdata = 14'h0040; tick();
    ram_wren = 0; ram_rden = 1; ram_raddr = 8'd5; tick();
    total++;
    if (ram_q !== 8'hFF) $display("FAIL ram_rd5 got %h want ff", ram_q); else passed++;
    ram_raddr = 8'd6; tick();
    total++;
    if (ram_q !== 8'h01) $display("FAIL ram_rd6 got %h want 01", ram_q); else passed++;
    ram_rden = 0; ram_raddr = 8'd5; tick(); tick();
    total++;
    if (ram_q !== 8'h01) $display("FAIL ram_hold got %h want 01", ram_q); else passed++;
  endtask

  task automatic test_same_addr();
    ram_wren = 1; ram_waddr = 8'd7; ram_wdata = 14'h0440; tick();
    ram_rden = 1; ram_raddr = 8'd7; ram_wdata = 14'h0AC0; tick();
    ram_wren = 0;
    total++;
    if (ram_q !== 8'h11) $display("FAIL ram_collide got %h want 11", ram_q); else passed++;
    tick(); ram_rden = 0;
    total++;
    if (ram_q !== 8'h2B) $display("FAIL ram_after_collide got %h want 2b", ram_q); else passed++;
  endtask

  task automatic test_async_reset();
    clear_enable = 1; delay_enable = 1; ram_rden = 1; ram_raddr = 8'd6;
    repeat (5) tick();
    clear_enable = 0; delay_enable = 0; ram_rden = 0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    total++;
    if ({clear_x, clear_y, clear_finished, delay_finished, ram_q} !== 26'd0)
      $display("FAIL async_reset got x=%0d y=%0d cf=%b df=%b q=%h want all zero",
               clear_x, clear_y, clear_finished, delay_finished, ram_q);
    else passed++;
    #2 reset = 1'b0;
    ram_rden = 1; ram_raddr = 8'd5; tick(); ram_rden = 0;
    total++;
    if (ram_q !== 8'hFF) $display("FAIL ram_survives_reset got %h want ff", ram_q); else passed++;
  endtask

  task automatic test_random();
    ram_wren = 1;
    for (int a = 0; a < 256; a++) begin
      ram_waddr = 8'(a); ram_wdata = 14'($urandom); tick();
    end
    for (int i = 0; i < 400; i++) begin
      clear_enable = ($urandom_range(0, 3) != 0);
      clear_reset  = ($urandom_range(0, 29) == 0);
      delay_enable = ($urandom_range(0, 2) != 0);
      delay_reset  = ($urandom_range(0, 19) == 0);
      ram_wren     = $urandom_range(0, 1) == 1;
      ram_rden     = $urandom_range(0, 1) == 1;
      ram_waddr    = 8'($urandom_range(0, 15));
      ram_raddr    = 8'($urandom_range(0, 15));
      ram_wdata    = 14'($urandom);
      tick();
      total++;
      if ({clear_x, clear_y, clear_finished, clear_color, delay_finished, ram_q} !==
          {8'(p_m % H_T), 8'(p_m / H_T), cf_m, BG_T, df_m, q_m})
        $display("FAIL random[%0d] got x=%0d y=%0d cf=%b col=%h df=%b q=%h want x=%0d y=%0d cf=%b df=%b q=%h",
                 i, clear_x, clear_y, clear_finished, clear_color, delay_finished, ram_q,
                 p_m % H_T, p_m / H_T, cf_m, df_m, q_m);
      else passed++;
    end
    clear_enable = 0; clear_reset = 0; delay_enable = 0; delay_reset = 0;
    ram_wren = 0; ram_rden = 0;
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_clear_pause_reset();
    test_delay();
    test_ram();
    test_same_addr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
